shift_sequencer: RTL
====================

SHIFT_SEQUENCER -- requirements
Module: shift_sequencer

Interface
REQ-001 The block SHALL have parameter WIDTH, default 4: width of the data path and of the driven shift register.
REQ-002 The block SHALL have parameter CNT_W, default 3: width of the shift-count field.
REQ-003 The block SHALL have port clk  input  1  the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rst_n  input  1  reset, synchronous and active-low.
REQ-005 The block SHALL have port cmd_valid  input  1  a command is present on cmd_data/cmd_dir/cmd_count.
REQ-006 The block SHALL have port cmd_ready  output  1  the block accepts a command this cycle.
REQ-007 The block SHALL have port cmd_data  input  WIDTH  value to parallel-load.
REQ-008 The block SHALL have port cmd_dir  input  1  shift direction: 1 = left (toward MSB, zero fill); 0 = right (zero fill).
REQ-009 The block SHALL have port cmd_count  input  CNT_W  number of shift cycles after the load, 0 to 2^CNT_W-1.
REQ-010 The block SHALL have port load  output  1  parallel-load strobe to the downstream shift register.
REQ-011 The block SHALL have port lr  output  1  direction to the downstream shift register; 1 = left.
REQ-012 The block SHALL have port d  output  WIDTH  load data to the downstream shift register.
REQ-013 The block SHALL have port busy  output  1  a command is in progress.
REQ-014 The block SHALL have port done  output  1  single-cycle completion pulse.
REQ-015 The block SHALL have port result  output  WIDTH  expected downstream register value at completion; held until the next done or reset.

Function
REQ-016 The block SHALL implement the FSM states IDLE, LOAD, SHIFT and DONE.
REQ-017 cmd_ready SHALL be 1 only in IDLE; a command SHALL be accepted at a rising edge where cmd_valid=1, cmd_ready=1 and rst_n=1, latching data, dir and count.
REQ-018 Transitions SHALL be as follows: IDLE->LOAD on acceptance; LOAD->SHIFT if count>0, else LOAD->DONE; SHIFT->DONE after exactly count SHIFT cycles; DONE->IDLE unconditionally.
REQ-019 In LOAD: load=1, d=latched data, lr=latched dir.
REQ-020 In SHIFT: load=0, lr=latched dir, d=latched data.
REQ-021 In IDLE and DONE: load=0, lr=0, d=0.
REQ-022 The block SHALL keep a shadow register that mirrors the downstream register every cycle: it loads d when load=1, otherwise it shifts left or right by one with zero fill, per lr.
REQ-023 On entry to DONE, result SHALL be the latched data shifted count times in dir with zero fill. A count >= WIDTH SHALL give result 0.
REQ-024 Timing: with acceptance at the edge ending cycle 0, load=1 in cycle 1, SHIFT in cycles 2..count+1, and done=1 in cycle count+2 with result valid in the same cycle.
REQ-025 busy SHALL be 1 in LOAD, SHIFT and DONE, and 0 in IDLE.
REQ-026 cmd_valid asserted outside IDLE SHALL be ignored with no side effects. The command SHALL be accepted on the first IDLE cycle, which allows back-to-back commands with one IDLE cycle between done and the next load.
REQ-027 The downstream register keeps shifting right in IDLE/DONE. result SHALL be a snapshot taken at DONE entry and SHALL NOT track later shadow changes.

Reset
REQ-028 At any rising edge with rst_n=0, the block SHALL enter IDLE and clear the shadow register, the latched data/dir/count, and result to 0.
REQ-029 After reset: load=0, lr=0, d=0, busy=0, done=0, cmd_ready=1.
REQ-030 Reset in LOAD, SHIFT or DONE SHALL abort the command with no done pulse.
REQ-031 A command presented during a reset edge SHALL NOT be accepted.

Verification
REQ-032 The bench SHALL cover: data=1011, dir=1, count=1 -> load=1/d=1011 in cycle 1, one SHIFT cycle with lr=1, done=1 in cycle 3, result=0110.
REQ-033 The bench SHALL cover: data=1011, dir=0, count=2 -> two SHIFT cycles with lr=0, done in cycle 4, result=0010.
REQ-034 The bench SHALL cover: data=1001, count=0 -> LOAD then DONE, done in cycle 2, result=1001, no SHIFT cycle.
REQ-035 The bench SHALL cover: data=1111, dir=1, count=7 -> done in cycle 9, result=0000, cmd_ready=0 in cycles 1..9.
REQ-036 The bench SHALL cover: rst_n=0 for one edge during SHIFT -> next cycle IDLE, busy=0, load=0, result=0, and no done pulse.
REQ-037 The bench SHALL cover: cmd_valid held high with two commands queued -> second accepted in the IDLE cycle after done; load pulses exactly once per command; result updates only at each done.

Source files
------------

// File: rtl/shift_sequencer.sv
// Shift sequencer: loads a downstream shift register, then drives it
// through N shift cycles and reports the value it ends up holding.
module shift_sequencer #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [WIDTH-1:0] cmd_data,
  input  logic             cmd_dir,
  input  logic [CNT_W-1:0] cmd_count,
  output logic             load,
  output logic             lr,
  output logic [WIDTH-1:0] d,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    SHIFT = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             dir_q, dir_d;
  logic [CNT_W-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] shadow_q, shadow_d;
  logic [WIDTH-1:0] result_q, result_d;
  logic             accept;

  assign accept = cmd_valid && (state_q == IDLE);

  // Next state, command latch and remaining-shift counter.
  always_comb begin
    state_d = state_q;
    data_d  = data_q;
    dir_d   = dir_q;
    rem_d   = rem_q;
    unique case (state_q)
      IDLE: begin
        if (accept) begin
          state_d = LOAD;
          data_d  = cmd_data;
          dir_d   = cmd_dir;
          rem_d   = cmd_count;
        end
      end
      LOAD: begin
        state_d = (rem_q == '0) ? DONE : SHIFT;
      end
      SHIFT: begin
        rem_d = rem_q - CNT_W'(1);
        if (rem_q == CNT_W'(1)) state_d = DONE;
      end
      DONE: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Downstream control outputs decoded from the state.
  always_comb begin
    load      = 1'b0;
    lr        = 1'b0;
    d         = '0;
    busy      = 1'b1;
    done      = 1'b0;
    cmd_ready = 1'b0;
    unique case (state_q)
      IDLE: begin
        busy      = 1'b0;
        cmd_ready = 1'b1;
      end
      LOAD: begin
        load = 1'b1;
        lr   = dir_q;
        d    = data_q;
      end
      SHIFT: begin
        lr = dir_q;
        d  = data_q;
      end
      DONE: begin
        done = 1'b1;
      end
      default: busy = 1'b0;
    endcase
  end

  // Shadow copy of the downstream register; result snapshots it on DONE entry.
  always_comb begin
    if (load)    shadow_d = d;
    else if (lr) shadow_d = shadow_q << 1;
    else         shadow_d = shadow_q >> 1;
    result_d = (state_d == DONE) ? shadow_d : result_q;
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      data_q   <= '0;
      dir_q    <= 1'b0;
      rem_q    <= '0;
      shadow_q <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      data_q   <= data_d;
      dir_q    <= dir_d;
      rem_q    <= rem_d;
      shadow_q <= shadow_d;
      result_q <= result_d;
    end
  end

  assign result = result_q;

endmodule
